sort_result_streamer: RTL
=========================

SORT_RESULT_STREAMER -- requirements
Module: sort_result_streamer

Interface
REQ-001 SHALL have parameter LOG_INPUT, default 5, log2 of element count N = 2**LOG_INPUT.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per element.
REQ-003 SHALL have parameter ASCENDING, default 1: 1 = expected non-decreasing order, 0 = non-increasing.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port y_valid  input  1  sorter result valid pulse.
REQ-007 SHALL have port y  input  DATA_WIDTH*N  sorted vector; element i = y[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-008 SHALL have port y_ready  output  1  high when a y_valid in the current cycle will be captured.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  streamed element.
REQ-010 SHALL have port m_valid  output  1  m_data valid.
REQ-011 SHALL have port m_ready  input  1  downstream accept.
REQ-012 SHALL have port m_index  output  LOG_INPUT  index of the element on m_data.
REQ-013 SHALL have port m_last  output  1  high with element N-1.
REQ-014 SHALL have port drop_err  output  1  sticky: a vector was lost.
REQ-015 SHALL have port order_err  output  1  sticky: an ordering violation was detected.

Function
REQ-016 SHALL implement FSM states IDLE and STREAM.
REQ-017 In IDLE, y_valid=1 SHALL capture all N elements into an internal buffer, set index to 0, and move to STREAM.
REQ-018 m_valid SHALL rise the cycle after capture (1-cycle latency) and SHALL be high only in STREAM.
REQ-019 In STREAM, m_data SHALL be buf[index], m_index SHALL be index, and m_last SHALL be (index==N-1).
REQ-020 A beat SHALL transfer on m_valid&&m_ready; index increments by 1 per beat; with m_ready=0, m_data/m_index SHALL hold stable.
REQ-021 A beat with index==N-1 SHALL return the FSM to IDLE; index SHALL not wrap within a frame.
REQ-022 y_ready SHALL be high in IDLE, and in STREAM during a cycle whose final beat (index==N-1, m_ready=1) transfers.
REQ-023 A y_valid coinciding with that final beat SHALL be captured and the FSM SHALL stay in STREAM with index 0, with no idle bubble.
REQ-024 A y_valid while y_ready=0 SHALL be discarded without disturbing the current frame and SHALL set drop_err.
REQ-025 Elements SHALL be compared as unsigned DATA_WIDTH values.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, index=0, m_valid=0, m_last=0, m_index=0, m_data=0, drop_err=0, and order_err=0, including mid-frame; the partial frame is discarded.
REQ-027 Buffer contents need not be reset.
REQ-028 drop_err and order_err SHALL clear only on reset.

Configuration
REQ-029 Macro SORT_ORDER_CHECK_EN SHALL, when defined, enable the order checker: on each transferred beat with index>0, order_err SHALL be set if the element is below the previous one (ASCENDING=1) or above it (ASCENDING=0).
REQ-030 The order checker SHALL not compare across frame boundaries.
REQ-031 Without SORT_ORDER_CHECK_EN, order_err SHALL be tied to 0, the port SHALL be retained, and no previous-element register SHALL be built.

Verification (LOG_INPUT=2, DATA_WIDTH=32, ASCENDING=1, macro defined unless noted)
REQ-032 y = {4,3,2,1} (element0=1), y_valid one cycle, m_ready=1 -> m_data 1,2,3,4 on consecutive cycles starting 1 cycle after capture; m_last only with 4; order_err=0.
REQ-033 Same frame with m_ready toggling 1,0,1,0... -> each element held while stalled, no duplicates or skips, m_index 0..3.
REQ-034 Second y_valid (y={8,7,6,5}) asserted in the final-beat cycle -> 1,2,3,4,5,6,7,8 back-to-back; drop_err=0.
REQ-035 y_valid asserted while m_index=1 mid-frame -> vector ignored, current frame completes unchanged, drop_err=1 until reset.
REQ-036 y = {1,2,3,4} (unsorted for ascending) -> order_err=1 after the second beat; without the macro -> order_err stays 0.
REQ-037 rst_n pulled low while m_index=2 -> m_valid=0 immediately; after release, FSM is IDLE, y_ready=1, and both errors=0.

Source files
------------

// File: rtl/sort_result_streamer.sv
// Streams a sorted vector one element per handshake, with drop and optional order checking.
// Optional order checker enabled by defining SORT_ORDER_CHECK_EN.
module sort_result_streamer #(
   parameter int LOG_INPUT  = 5,
   parameter int DATA_WIDTH = 32,
   parameter int ASCENDING  = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             y_valid,
   input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] y,
   output logic                             y_ready,
   output logic [DATA_WIDTH-1:0]            m_data,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [LOG_INPUT-1:0]             m_index,
   output logic                             m_last,
   output logic                             drop_err,
   output logic                             order_err
);

   localparam int N = 2**LOG_INPUT;
   localparam logic [LOG_INPUT-1:0] LAST_IDX = LOG_INPUT'(N-1);
   localparam logic [LOG_INPUT-1:0] ONE_IDX  = LOG_INPUT'(1);
   localparam logic [LOG_INPUT-1:0] ZERO_IDX = LOG_INPUT'(0);
   localparam bit ASC_ORDER = (ASCENDING != 0);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t                  state_r;
   logic [DATA_WIDTH-1:0]   buf_r [N];
   logic [DATA_WIDTH-1:0]   m_data_r;
   logic [LOG_INPUT-1:0]    m_index_r;
   logic                    m_valid_r;
   logic                    m_last_r;
   logic                    drop_err_r;

   logic                    beat_s;
   logic                    final_beat_s;
   logic                    y_ready_s;
   logic                    capture_s;
   logic [LOG_INPUT-1:0]    next_idx_s;

   // Handshake decode; y_ready depends on the live m_ready so a new vector can chain onto the final beat.
   always_comb begin
      beat_s       = m_valid_r && m_ready;
      final_beat_s = beat_s && m_last_r;
      y_ready_s    = (state_r == IDLE) || final_beat_s;
      capture_s    = y_valid && y_ready_s;
      next_idx_s   = m_index_r + ONE_IDX;
   end

   // Element buffer; contents are don't-care until a capture.
   always_ff @(posedge clk) begin
      if (capture_s) begin
         for (int i = 0; i < N; i++) begin
            buf_r[i] <= y[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Streaming FSM with registered stream outputs and sticky drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         m_data_r   <= {DATA_WIDTH{1'b0}};
         m_index_r  <= ZERO_IDX;
         m_valid_r  <= 1'b0;
         m_last_r   <= 1'b0;
         drop_err_r <= 1'b0;
      end else begin
         if (y_valid && !y_ready_s) begin
            drop_err_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (capture_s) begin
                  state_r   <= STREAM;
                  m_data_r  <= y[DATA_WIDTH-1:0];
                  m_index_r <= ZERO_IDX;
                  m_valid_r <= 1'b1;
                  m_last_r  <= (LAST_IDX == ZERO_IDX);
               end
            end
            STREAM: begin
               if (capture_s) begin
                  // Back-to-back frame: restart at element 0 without leaving STREAM.
                  m_data_r  <= y[DATA_WIDTH-1:0];
                  m_index_r <= ZERO_IDX;
                  m_valid_r <= 1'b1;
                  m_last_r  <= (LAST_IDX == ZERO_IDX);
               end else if (final_beat_s) begin
                  state_r   <= IDLE;
                  m_valid_r <= 1'b0;
                  m_last_r  <= 1'b0;
               end else if (beat_s) begin
                  m_data_r  <= buf_r[next_idx_s];
                  m_index_r <= next_idx_s;
                  m_last_r  <= (next_idx_s == LAST_IDX);
               end
            end
            default: begin
               state_r   <= IDLE;
               m_valid_r <= 1'b0;
               m_last_r  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SORT_ORDER_CHECK_EN
   logic [DATA_WIDTH-1:0] prev_r;
   logic                  order_err_r;

   function automatic logic out_of_order(input logic [DATA_WIDTH-1:0] prev,
                                         input logic [DATA_WIDTH-1:0] cur);
      if (ASC_ORDER) begin
         return cur < prev;
      end else begin
         return cur > prev;
      end
   endfunction

   // Order checker; element 0 of each frame is never compared against the previous frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_r      <= {DATA_WIDTH{1'b0}};
         order_err_r <= 1'b0;
      end else begin
         if (beat_s) begin
            prev_r <= m_data_r;
            if ((m_index_r != ZERO_IDX) && out_of_order(prev_r, m_data_r)) begin
               order_err_r <= 1'b1;
            end
         end
      end
   end

   assign order_err = order_err_r;
`else
   // Sort direction only matters when the checker is built.
   assign order_err = ASC_ORDER && 1'b0;
`endif

   assign y_ready  = y_ready_s;
   assign m_data   = m_data_r;
   assign m_valid  = m_valid_r;
   assign m_index  = m_index_r;
   assign m_last   = m_last_r;
   assign drop_err = drop_err_r;

endmodule
